// File: rtl/pcs_tx_pkg.sv
// Shared 10GBASE-R PCS definitions: block type codes, TX states,
// sync headers and the fixed EBLOCK_T / LBLOCK_T coded blocks.
package pcs_tx_pkg;

    typedef enum logic [2:0] {
        BT_S = 3'b000,
        BT_C = 3'b001,
        BT_E = 3'b010,
        BT_D = 3'b011,
        BT_T = 3'b100
    } blk_type_e;

    typedef enum logic [2:0] {
        TX_INIT = 3'd0,
        TX_C    = 3'd1,
        TX_D    = 3'd2,
        TX_T    = 3'd3,
        TX_E    = 3'd4
    } tx_state_e;

    localparam logic [1:0] SH_CTRL = 2'b01;
    localparam logic [1:0] SH_DATA = 2'b10;

    localparam logic [65:0] EBLOCK_T = {
        {8{7'h1E}},
        8'h1E,
        SH_CTRL
    };

    localparam logic [65:0] LBLOCK_T = {
        28'h0,
        4'h0,
        8'h01,
        8'h00,
        8'h00,
        8'h4B,
        SH_CTRL
    };

    // Codes 101..111 are not defined and behave as an error block.
    function automatic blk_type_e to_blk_type(input logic [2:0] t);
        blk_type_e r;
        unique case (t)
            3'b000:  r = BT_S;
            3'b001:  r = BT_C;
            3'b011:  r = BT_D;
            3'b100:  r = BT_T;
            default: r = BT_E;
        endcase
        return r;
    endfunction

endpackage

// File: rtl/pcs_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
// Holds at all-ones once reached.
module pcs_sat_counter #(
    parameter int W = 16
) (
    input  logic         clk,
    input  logic         reset,
    input  logic         inc,
    output logic [W-1:0] cnt
);

    // Count up on inc, stop at all-ones.
    always_ff @(posedge clk) begin
        if (reset) begin
            cnt <= '0;
        end else if (inc && (cnt != {W{1'b1}})) begin
            cnt <= cnt + 1'b1;
        end
    end

endmodule

// File: rtl/pcs_tx_sm.sv
// 10GBASE-R PCS transmit state machine, one 66-bit block per valid cycle.
// Optional error-block counter enabled by defining PCS_TX_ERR_CNT_EN.
module pcs_tx_sm
    import pcs_tx_pkg::*;
#(
    parameter int ERR_CNT_W = 16
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 in_valid,
    input  logic [2:0]           t_type,
    input  logic [65:0]          encoded_in,
    output logic [65:0]          tx_coded,
    output logic                 out_valid
`ifdef PCS_TX_ERR_CNT_EN
    ,
    output logic [ERR_CNT_W-1:0] err_blk_cnt
`endif
);

    tx_state_e   state;
    tx_state_e   next_state;
    logic [65:0] next_coded;
    blk_type_e   bt;

    assign bt = to_blk_type(t_type);

    // Next state from current state and block type; output follows
    // the destination state.
    always_comb begin
        next_state = TX_E;
        next_coded = encoded_in;
        unique case (state)
            TX_INIT, TX_C, TX_T: begin
                unique case (bt)
                    BT_C:    next_state = TX_C;
                    BT_S:    next_state = TX_D;
                    default: next_state = TX_E;
                endcase
            end
            TX_D: begin
                unique case (bt)
                    BT_D:    next_state = TX_D;
                    BT_T:    next_state = TX_T;
                    default: next_state = TX_E;
                endcase
            end
            TX_E: begin
                unique case (bt)
                    BT_C:    next_state = TX_C;
                    BT_D:    next_state = TX_D;
                    BT_T:    next_state = TX_T;
                    default: next_state = TX_E;
                endcase
            end
            default: next_state = TX_E;
        endcase
        unique case (next_state)
            TX_INIT: next_coded = LBLOCK_T;
            TX_E:    next_coded = EBLOCK_T;
            default: next_coded = encoded_in;
        endcase
    end

    // State and registered outputs advance only on valid blocks.
    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= TX_INIT;
            tx_coded  <= LBLOCK_T;
            out_valid <= 1'b0;
        end else begin
            out_valid <= in_valid;
            if (in_valid) begin
                state    <= next_state;
                tx_coded <= next_coded;
            end
        end
    end

    if (ERR_CNT_W < 1) begin : g_bad_cnt_w
    end

`ifdef PCS_TX_ERR_CNT_EN
    logic err_inc;

    assign err_inc = in_valid && (next_state == TX_E);

    pcs_sat_counter #(
        .W(ERR_CNT_W)
    ) u_err_cnt (
        .clk  (clk),
        .reset(reset),
        .inc  (err_inc),
        .cnt  (err_blk_cnt)
    );
`endif

endmodule

// File: tb/tb_pcs_tx_sm.sv
// Self-checking bench for pcs_tx_sm: directed scenarios plus random
// traffic against a packet-framing reference model.
module tb_pcs_tx_sm;

    localparam int CW = 4;

    localparam logic [2:0] TS = 3'b000;
    localparam logic [2:0] TC = 3'b001;
    localparam logic [2:0] TE = 3'b010;
    localparam logic [2:0] TD = 3'b011;
    localparam logic [2:0] TT = 3'b100;

    localparam int K_INIT = 0;
    localparam int K_OUT  = 1;
    localparam int K_PKT  = 2;
    localparam int K_ERR  = 3;

    logic          clk = 1'b0;
    logic          reset = 1'b0;
    logic          in_valid = 1'b0;
    logic [2:0]    t_type = 3'b000;
    logic [65:0]   encoded_in = '0;
    logic [65:0]   tx_coded;
    logic          out_valid;
`ifdef PCS_TX_ERR_CNT_EN
    logic [CW-1:0] err_blk_cnt;
`endif

    logic [65:0] eblk;
    logic [65:0] lblk;

    int          cls;
    logic [65:0] exp_coded;
    logic        exp_ov;
    int          exp_cnt;
    int          n_chk = 0;
    int          n_bad = 0;

    pcs_tx_sm #(
        .ERR_CNT_W(CW)
    ) dut (
        .clk       (clk),
        .reset     (reset),
        .in_valid  (in_valid),
        .t_type    (t_type),
        .encoded_in(encoded_in),
        .tx_coded  (tx_coded),
        .out_valid (out_valid)
`ifdef PCS_TX_ERR_CNT_EN
        ,
        .err_blk_cnt(err_blk_cnt)
`endif
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [65:0] got,
                       input logic [65:0] exp);
        n_chk++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    function automatic logic [65:0] rnd66();
        logic [65:0] r;
        r = {$urandom(), $urandom(), 2'($urandom())};
        return r;
    endfunction

    // Framing rules: a packet opens with S, carries D, closes with T;
    // C only outside a packet; after an error D/T/C resynchronise.
    task automatic model_blk(input logic [2:0] t, input logic [65:0] d);
        bit ok;
        int ncls;
        ok = 1'b0;
        ncls = K_ERR;
        case (t)
            TS: begin
                ok = (cls == K_OUT) || (cls == K_INIT);
                ncls = K_PKT;
            end
            TC: begin
                ok = (cls != K_PKT);
                ncls = K_OUT;
            end
            TD: begin
                ok = (cls == K_PKT) || (cls == K_ERR);
                ncls = K_PKT;
            end
            TT: begin
                ok = (cls == K_PKT) || (cls == K_ERR);
                ncls = K_OUT;
            end
            default: ok = 1'b0;
        endcase
        if (ok) begin
            cls = ncls;
            exp_coded = d;
        end else begin
            cls = K_ERR;
            exp_coded = eblk;
            if (exp_cnt < (1 << CW) - 1) exp_cnt++;
        end
    endtask

    task automatic check_out(input string tag);
        chk({tag, ".ov"}, {65'd0, out_valid}, {65'd0, exp_ov});
        chk({tag, ".coded"}, tx_coded, exp_coded);
`ifdef PCS_TX_ERR_CNT_EN
        chk({tag, ".cnt"}, {{(66-CW){1'b0}}, err_blk_cnt}, 66'(exp_cnt));
`endif
    endtask

    task automatic step(input string tag, input logic v,
                        input logic [2:0] t);
        logic [65:0] d;
        d = rnd66();
        @(negedge clk);
        reset = 1'b0;
        in_valid = v;
        t_type = t;
        encoded_in = d;
        exp_ov = v;
        if (v) model_blk(t, d);
        @(posedge clk);
        #1;
        check_out(tag);
    endtask

    task automatic do_reset(input int n);
        for (int i = 0; i < n; i++) begin
            @(negedge clk);
            reset = 1'b1;
            in_valid = 1'($urandom());
            t_type = TC;
            encoded_in = rnd66();
            cls = K_INIT;
            exp_coded = lblk;
            exp_ov = 1'b0;
            exp_cnt = 0;
            @(posedge clk);
            #1;
            check_out("rst");
        end
    endtask

    initial begin
        eblk = {{8{7'h1E}}, 8'h1E, 2'b01};
        lblk = 66'd0;
        lblk[1:0] = 2'b01;
        lblk[9:2] = 8'h4B;
        lblk[33:26] = 8'h01;
        cls = K_INIT;
        exp_coded = lblk;
        exp_ov = 1'b0;
        exp_cnt = 0;

        do_reset(3);
        step("idle0", 1'b1, TC);
        step("idle1", 1'b1, TC);

        step("pk.c", 1'b1, TC);
        step("pk.s", 1'b1, TS);
        step("pk.d0", 1'b1, TD);
        step("pk.d1", 1'b1, TD);
        step("pk.t", 1'b1, TT);
        step("pk.c2", 1'b1, TC);

        do_reset(1);
        step("e.c", 1'b1, TC);
        step("e.d", 1'b1, TD);
        step("e.e", 1'b1, TE);
        step("e.c2", 1'b1, TC);

        step("d.s0", 1'b1, TS);
        step("d.s1", 1'b1, TS);
        step("d.d", 1'b1, TD);
        step("d.t", 1'b1, TT);

        step("p.s", 1'b1, TS);
        step("p.d", 1'b1, TD);
        for (int i = 0; i < 4; i++) step("p.gap", 1'b0, TE);
        step("p.d2", 1'b1, TD);
        step("p.t", 1'b1, TT);

        step("r.s", 1'b1, TS);
        step("r.d", 1'b1, TD);
        do_reset(2);
        step("r.d2", 1'b1, TD);

        for (int i = 0; i < 20; i++) step("sat", 1'b1, 3'($urandom_range(5, 7)));

        do_reset(1);
        for (int i = 0; i < 400; i++) begin
            if ($urandom_range(0, 99) == 0) begin
                do_reset(1);
            end else begin
                step("rnd", ($urandom_range(0, 9) < 8),
                     3'($urandom_range(0, 7)));
            end
        end

        $display("test done: total=%0d bad=%0d", n_chk, n_bad);
        $finish;
    end

endmodule
